// File: rtl/cla_nibble_sequencer_if.sv
// Request/response bus of the nibble-serial wide adder.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface cla_nibble_sequencer_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Drives an external combinational 4-bit CLA slice one nibble per cycle, LSB first,
// chaining the carry through a register and returning the full word sum.
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_nibble_sequencer_if.slave bus,
  output logic [3:0]           nibble_a_o,
  output logic [3:0]           nibble_b_o,
  output logic                 nibble_cin_o,
  input  logic [3:0]           nibble_s_i,
  input  logic                 nibble_cout_i,
  output logic                 busy_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [W-1:0]  out_sum_q, out_sum_d;
  logic          out_cout_q, out_cout_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_valid_q, out_valid_d;

  // Signed overflow: like-signed operands producing a result of the other sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Next-state, datapath update and slice drive.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    out_sum_d    = out_sum_q;
    out_cout_d   = out_cout_q;
    out_ovf_d    = out_ovf_q;
    out_valid_d  = out_valid_q;
    nibble_a_o   = 4'h0;
    nibble_b_o   = 4'h0;
    nibble_cin_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = {IW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        nibble_a_o   = a_q[{idx_q, 2'b00} +: 4];
        nibble_b_o   = b_q[{idx_q, 2'b00} +: 4];
        nibble_cin_o = carry_q;
        sum_d[{idx_q, 2'b00} +: 4] = nibble_s_i;
        carry_d = nibble_cout_i;
        if (idx_q == LAST_IDX) begin
          // Index parks at zero so it never steps past the last nibble.
          idx_d       = {IW{1'b0}};
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = sum_d;
          out_cout_d  = nibble_cout_i;
          out_ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], nibble_s_i[3]);
        end else begin
          idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= {IW{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sum_q       <= {W{1'b0}};
      out_sum_q   <= {W{1'b0}};
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed and randomized checks of cla_nibble_sequencer against a word-level arithmetic model,
// with a behavioural CLA slice closing the loop.
module tb_cla_nibble_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] nib_a, nib_b, nib_s;
  logic       nib_cin, nib_cout, busy;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  cla_nibble_sequencer_if #(.NIBBLES(NIB)) bus ();

  cla_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .nibble_a_o   (nib_a),
    .nibble_b_o   (nib_b),
    .nibble_cin_o (nib_cin),
    .nibble_s_i   (nib_s),
    .nibble_cout_i(nib_cout),
    .busy_o       (busy)
  );

  assign {nib_cout, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, nib_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  // Carry into nibble k: carry out of adding the low 4k bits.
  function automatic logic ref_carry_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int k);
    longint unsigned lo, t;
    lo = (64'd1 << (4 * k)) - 64'd1;
    t  = (longint'(a) & lo) + (longint'(b) & lo) + longint'(cin);
    return ((t >> (4 * k)) & 64'd1) != 64'd0;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Accept one request, check every slice step, end with the result presented in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W+1:0] r;
    r = ref_add(a, b, cin);
    wait_ready();
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a = ~a; bus.in_b = ~b; bus.in_cin = ~cin;
    for (int k = 0; k < NIB; k++) begin
      chk("step_nib_a", 64'(nib_a), 64'(a[4*k +: 4]));
      chk("step_nib_b", 64'(nib_b), 64'(b[4*k +: 4]));
      chk("step_nib_cin", 64'(nib_cin), 64'(ref_carry_in(a, b, cin, k)));
      chk("step_busy", 64'(busy), 64'd1);
      chk("step_in_ready", 64'(bus.in_ready), 64'd0);
      chk("step_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    chk("done_valid", 64'(bus.out_valid), 64'd1);
    chk("done_sum", 64'(bus.out_sum), 64'(r[W-1:0]));
    chk("done_cout", 64'(bus.out_cout), 64'(r[W]));
    chk("done_ovf", 64'(bus.out_ovf), 64'(r[W+1]));
    chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    chk("done_nib_a", {56'd0, nib_a, nib_b}, 64'd0);
    chk("done_nib_cin", 64'(nib_cin), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ca, cb, na, nb;
    logic         cc, nc;
    logic [W+1:0] r;
    int           n, acc, prev;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_cout_ovf", {62'd0, bus.out_cout, bus.out_ovf}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_nibbles", {55'd0, nib_a, nib_b, nib_cin}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed sums, out_ready already high when DONE is entered.
    run_op(16'h1234, 16'h4321, 1'b0);
    tick();
    chk("back_to_idle", 64'(busy), 64'd0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    tick();
    run_op(16'h7FFF, 16'h0001, 1'b0);
    tick();
    run_op(16'h00FF, 16'h0F00, 1'b1);
    tick();
    run_op(16'h8000, 16'h8000, 1'b0);
    tick();

    // Backpressure: result held, stray request ignored, then accepted after release.
    bus.out_ready = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i == 2);
      bus.in_a = 16'hAAAA; bus.in_b = 16'h5555;
      tick();
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum", 64'(bus.out_sum), 64'h3333);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 16'h0102; bus.in_b = 16'h0304; bus.in_cin = 1'b1;
    tick();
    chk("rel_valid", 64'(bus.out_valid), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("rel_sum_kept", 64'(bus.out_sum), 64'h3333);
    tick();
    bus.in_valid = 1'b0;
    chk("rel_accept", 64'(busy), 64'd1);
    wait_valid(n);
    chk("rel_latency", 64'(n), 64'(NIB));
    chk("rel_sum", 64'(bus.out_sum), 64'h0407);
    tick();

    // Asynchronous reset at idx 2 aborts the operation.
    wait_ready();
    bus.in_valid = 1'b1; bus.in_a = 16'h5A5A; bus.in_b = 16'h1234; bus.in_cin = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_nib_a", 64'(nib_a), 64'hA);
    rst_n = 1'b0;
    #1;
    chk("arst_sum", 64'(bus.out_sum), 64'd0);
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_nibbles", {55'd0, nib_a, nib_b, nib_cin}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("aborted_no_valid", 64'(bus.out_valid), 64'd0);
    end
    run_op(16'h5A5A, 16'h1234, 1'b1);
    tick();

    // Back-to-back random operations with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
    wait_ready();
    bus.in_a = ca; bus.in_b = cb; bus.in_cin = cc; bus.in_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 1000; k++) begin
      acc = cyc;
      if (k > 0) chk("accept_spacing", 64'(acc - prev), 64'(NIB + 2));
      prev = acc;
      tick();
      na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
      bus.in_a = na; bus.in_b = nb; bus.in_cin = nc;
      wait_valid(n);
      r = ref_add(ca, cb, cc);
      chk("rnd_latency", 64'(n), 64'(NIB));
      chk("rnd_sum", 64'(bus.out_sum), 64'(r[W-1:0]));
      chk("rnd_cout_ovf", {62'd0, bus.out_cout, bus.out_ovf}, {62'd0, r[W], r[W+1]});
      chk("rnd_in_ready_done", 64'(bus.in_ready), 64'd0);
      tick();
      chk("rnd_in_ready_idle", 64'(bus.in_ready), 64'd1);
      ca = na; cb = nb; cc = nc;
    end
    bus.in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
